// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares the read channel of one AXI4 slave between
// NUM_MASTERS requesters. One master is granted per burst. Its AR beat is
// forwarded to the slave, and R beats are routed back to it until the rlast
// handshake completes. The grant is held for the whole burst, so R routing
// never looks at RID.
//
// Handshake rule used on every channel: a beat transfers on a rising clock
// edge where valid and ready are both high. A source holds valid and its
// payload stable until that edge, and ready may depend combinationally on
// valid.
//
// Optional build macro AXI_RD_ARB_RR_EN selects round-robin arbitration.
// When it is defined, a priority pointer moves to grant+1 at each rlast
// handshake. When it is not defined, arbitration is fixed priority and
// index 0 is the highest.
module axi_rd_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 64,
  parameter int ID_WIDTH    = 8,
  localparam int SEL_WIDTH  = $clog2(NUM_MASTERS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0]   s_axi_arid,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [NUM_MASTERS*8-1:0]          s_axi_arlen,
  input  logic [NUM_MASTERS*3-1:0]          s_axi_arsize,
  input  logic [NUM_MASTERS*2-1:0]          s_axi_arburst,
  input  logic [NUM_MASTERS-1:0]            s_axi_arvalid,
  output logic [NUM_MASTERS-1:0]            s_axi_arready,
  output logic [NUM_MASTERS*ID_WIDTH-1:0]   s_axi_rid,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] s_axi_rdata,
  output logic [NUM_MASTERS*2-1:0]          s_axi_rresp,
  output logic [NUM_MASTERS-1:0]            s_axi_rlast,
  output logic [NUM_MASTERS-1:0]            s_axi_rvalid,
  input  logic [NUM_MASTERS-1:0]            s_axi_rready,
  output logic [ID_WIDTH-1:0]               m_axi_arid,
  output logic [ADDR_WIDTH-1:0]             m_axi_araddr,
  output logic [7:0]                        m_axi_arlen,
  output logic [2:0]                        m_axi_arsize,
  output logic [1:0]                        m_axi_arburst,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  input  logic [ID_WIDTH-1:0]               m_axi_rid,
  input  logic [DATA_WIDTH-1:0]             m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rlast,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready,
  output logic [SEL_WIDTH-1:0]              grant_idx,
  output logic                              busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e               state_q, state_d;
  logic [SEL_WIDTH-1:0] grant_q;
  logic [SEL_WIDTH-1:0] winner;
  logic                 any_req;
  logic                 last_hs;

  // Unpacked copies of the per-master AR payloads, so that the grant mux
  // can index them directly.
  logic [ID_WIDTH-1:0]   arid_a   [NUM_MASTERS];
  logic [ADDR_WIDTH-1:0] araddr_a [NUM_MASTERS];
  logic [7:0]            arlen_a  [NUM_MASTERS];
  logic [2:0]            arsize_a [NUM_MASTERS];
  logic [1:0]            arburst_a[NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign arid_a[g]    = s_axi_arid[g*ID_WIDTH +: ID_WIDTH];
    assign araddr_a[g]  = s_axi_araddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign arlen_a[g]   = s_axi_arlen[g*8 +: 8];
    assign arsize_a[g]  = s_axi_arsize[g*3 +: 3];
    assign arburst_a[g] = s_axi_arburst[g*2 +: 2];
  end

  assign any_req = |s_axi_arvalid;
  assign last_hs = (state_q == DATA) && m_axi_rvalid && s_axi_rready[grant_q] && m_axi_rlast;

`ifdef AXI_RD_ARB_RR_EN
  logic [SEL_WIDTH-1:0] ptr_q;
  logic [SEL_WIDTH:0]   cand_sum;
  logic [SEL_WIDTH-1:0] cand;

  // Round-robin pick: scan downward from the farthest candidate, so the
  // requester closest to the pointer is the one left in winner.
  always_comb begin
    winner   = '0;
    cand_sum = '0;
    cand     = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      cand_sum = {1'b0, ptr_q} + (SEL_WIDTH+1)'(i);
      if (cand_sum >= (SEL_WIDTH+1)'(NUM_MASTERS)) begin
        cand_sum = cand_sum - (SEL_WIDTH+1)'(NUM_MASTERS);
      end
      cand = cand_sum[SEL_WIDTH-1:0];
      if (s_axi_arvalid[cand]) winner = cand;
    end
  end

  // Priority pointer advances past the master whose burst just finished.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (last_hs) begin
      ptr_q <= (grant_q == SEL_WIDTH'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;
    end
  end
`else
  // Fixed-priority pick: the lowest requesting index wins.
  always_comb begin
    winner = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (s_axi_arvalid[SEL_WIDTH'(i)]) winner = SEL_WIDTH'(i);
    end
  end
`endif

  // State register and grant. The grant is captured only when leaving IDLE
  // and is held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) grant_q <= winner;
    end
  end

  // Next-state logic and handshake routing to and from the granted master.
  always_comb begin
    state_d       = state_q;
    s_axi_arready = '0;
    s_axi_rvalid  = '0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) state_d = ADDR;
      end
      ADDR: begin
        m_axi_arvalid          = 1'b1;
        s_axi_arready[grant_q] = m_axi_arready;
        if (m_axi_arready) state_d = DATA;
      end
      DATA: begin
        s_axi_rvalid[grant_q] = m_axi_rvalid;
        m_axi_rready          = s_axi_rready[grant_q];
        if (last_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_axi_arid    = arid_a[grant_q];
  assign m_axi_araddr  = araddr_a[grant_q];
  assign m_axi_arlen   = arlen_a[grant_q];
  assign m_axi_arsize  = arsize_a[grant_q];
  assign m_axi_arburst = arburst_a[grant_q];

  // The R payload goes to every master. Only rvalid marks who owns the beat.
  assign s_axi_rid   = {NUM_MASTERS{m_axi_rid}};
  assign s_axi_rdata = {NUM_MASTERS{m_axi_rdata}};
  assign s_axi_rresp = {NUM_MASTERS{m_axi_rresp}};
  assign s_axi_rlast = {NUM_MASTERS{m_axi_rlast}};

  assign grant_idx = grant_q;
  assign busy      = (state_q != IDLE);

endmodule
